sample_fifo_codec_if: RTL
=========================

# sample_fifo_codec_if

Elastic sample buffer between the note-synthesis/dynamics chain and the audio codec. It requests samples from the producer through `generate_next_sample`, stores each returned `sample_in` on `new_sample_ready`, and hands one sample to the codec per `ready_for_sample` strobe. It decouples the producer's variable latency from the codec's fixed sample rate and counts underruns and overflows.

## Interface
- `WIDTH`, 16, sample width in bits (two's complement).
- `DEPTH_LOG2`, 4, log2 of FIFO depth (16 entries).
- `TIMEOUT`, 255, maximum number of cycles spent waiting for `new_sample_ready` before a request is abandoned (8-bit counter).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `play_enable`  in  1  high = playback running.
- `sample_in`  in  WIDTH  sample from producer.
- `new_sample_ready`  in  1  one-cycle strobe: `sample_in` valid, push.
- `ready_for_sample`  in  1  one-cycle codec strobe: deliver next sample.
- `generate_next_sample`  out  1  one-cycle request pulse to producer.
- `sample_out`  out  WIDTH  registered sample to codec.
- `fifo_level`  out  DEPTH_LOG2+1  current entry count, 0..2^DEPTH_LOG2.
- `underrun_count`  out  8  saturating count of pops from an empty FIFO.
- `overflow`  out  1  sticky: a push arrived while the FIFO was full.

## Operation
- Storage is a circular buffer with `wr_ptr`/`rd_ptr` of width DEPTH_LOG2. Pointers wrap modulo depth. `fifo_level` is a separate counter.
- Request FSM:
  - IDLE → REQ when `play_enable` and `fifo_level` < depth − 1. One slot is reserved for the in-flight sample.
  - REQ: `generate_next_sample`=1 for exactly one cycle, then → WAIT.
  - WAIT → IDLE on `new_sample_ready`, or after TIMEOUT cycles without it.
  - Any state → IDLE when `play_enable`=0.
- At most one request is outstanding at a time.
- Push: `new_sample_ready` writes `sample_in` at `wr_ptr` in any state, including an unsolicited strobe. If the FIFO is full, the push is dropped and `overflow` is set.
- Pop: on `ready_for_sample` with the FIFO non-empty, `sample_out` ← head and the entry is removed. If the FIFO is empty, `sample_out` ← 0 and `underrun_count` increments, saturating at 255.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and `fifo_level` is unchanged.
- Push and pop together on an empty FIFO: no bypass. The pop counts as an underrun and outputs 0; the pushed sample is stored.
- Push and pop together on a full FIFO: the pop frees a slot and the push is accepted; `overflow` is not set.
- `play_enable`=0:
  - FIFO is flushed (pointers and level → 0) every cycle it is low.
  - Pushes are ignored.
  - `ready_for_sample` drives `sample_out` ← 0 and does not count as an underrun.
  - `underrun_count` and `overflow` are held.

## Timing
- Reset (`reset`=0 at a rising edge):
  - `sample_out`=0, `generate_next_sample`=0, `fifo_level`=0, `underrun_count`=0, `overflow`=0.
  - FSM in IDLE, pointers 0, timeout counter 0.
  - Takes effect mid-request, discarding the outstanding request and all buffered data.
- REQ pulse: first asserted the cycle after the FSM samples the IDLE condition true.
- Minimum spacing between request pulses is 3 cycles (REQ, WAIT with immediate response, IDLE).
- A sample pushed at edge N is deliverable by a `ready_for_sample` sampled at edge N+1. `sample_out` changes at that same edge.
- `sample_out` holds its value between pops.
- Timeout: the WAIT counter starts at 0 on entry and returns the FSM to IDLE on the edge where it reaches TIMEOUT−1. A later `new_sample_ready` is still pushed.
- `fifo_level` reflects the cycle's push/pop/flush at the same edge.

## Configuration
- `SAMPLE_FIFO_HOLD_LAST_EN` defined: an underrun pop leaves `sample_out` at the last delivered value instead of 0. `underrun_count` still increments. The `play_enable`=0 pop still outputs 0.
- Not defined: an underrun pop outputs 0.

## Test plan
- Reset then `play_enable`=1, producer answers each request 2 cycles later with 1, 2, 3…; no pops.
  - Requests stop at `fifo_level`=15; no further `generate_next_sample`; `overflow`=0.
- Fill with 1..15, then 15 `ready_for_sample` strobes 4 cycles apart, producer silent.
  - `sample_out` = 1..15 in order.
  - 16th strobe gives 0 (or 15 with HOLD_LAST) and `underrun_count`=1.
- Empty FIFO, 300 strobes, no pushes.
  - `underrun_count` saturates at 255.
- Full FIFO (16 via unsolicited pushes), then push 0x7FFF.
  - `overflow`=1, `fifo_level`=16.
  - Push and pop in the same cycle → level stays 16, `overflow` unchanged.
- Request issued, no response for 255 cycles.
  - FSM returns to IDLE and a new `generate_next_sample` pulse follows within 2 cycles.
- Mid-fill, drop `play_enable` one cycle, then drive `reset`=0 one cycle during WAIT.
  - `fifo_level`→0 after the flush.
  - All outputs return to their reset values after the reset.

Source files
------------

// File: rtl/sample_fifo_codec_if.sv
// rtl/sample_fifo_codec_if.sv - elastic producer-to-codec sample FIFO with request FSM
// Optional: SAMPLE_FIFO_HOLD_LAST_EN keeps the last delivered sample on an underrun pop.
module sample_fifo_codec_if #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  play_enable,
   input  logic [WIDTH-1:0]      sample_in,
   input  logic                  new_sample_ready,
   input  logic                  ready_for_sample,
   output logic                  generate_next_sample,
   output logic [WIDTH-1:0]      sample_out,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic [7:0]            underrun_count,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_REQ  = (DEPTH_LOG2+1)'(DEPTH-1);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [7:0]            TO_LAST  = 8'(TIMEOUT-1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t                state, state_nxt;
   logic [7:0]            wait_cnt, wait_cnt_nxt;
   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic                  fifo_empty, fifo_full, do_push, do_pop;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == LVL_FULL);
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = reset && play_enable && ready_for_sample && !fifo_empty;
   assign do_push = reset && play_enable && new_sample_ready && (!fifo_full || do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt            = state;
      wait_cnt_nxt         = wait_cnt;
      generate_next_sample = 1'b0;
      case (state)
         S_IDLE: begin
            // One slot stays free for the sample still in flight.
            if (play_enable && (fifo_level < LVL_REQ))
               state_nxt = S_REQ;
         end
         S_REQ: begin
            generate_next_sample = 1'b1;
            state_nxt            = S_WAIT;
            wait_cnt_nxt         = '0;
         end
         S_WAIT: begin
            if (new_sample_ready || (wait_cnt == TO_LAST)) begin
               state_nxt    = S_IDLE;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (!play_enable) begin
         state_nxt    = S_IDLE;
         wait_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= sample_in;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
         sample_out     <= '0;
         underrun_count <= '0;
         overflow       <= 1'b0;
      end else if (!play_enable) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         if (ready_for_sample)
            sample_out <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            sample_out <= mem[rd_ptr];
         end else if (ready_for_sample) begin
`ifdef SAMPLE_FIFO_HOLD_LAST_EN
            sample_out <= sample_out;
`else
            sample_out <= '0;
`endif
            if (underrun_count != 8'hFF)
               underrun_count <= underrun_count + 8'd1;
         end
         if (new_sample_ready && !do_push)
            overflow <= 1'b1;
         case ({do_push, do_pop})
            2'b10:   fifo_level <= fifo_level + LVL_ONE;
            2'b01:   fifo_level <= fifo_level - LVL_ONE;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

endmodule
